// File: rtl/snake_ctrl.sv
// rtl/snake_ctrl.sv - Snake game controller on an 80x60 grid of 10x10 px cells.
// Define SNAKE_WALL_WRAP_EN to wrap the head at the grid edges instead of dying.
module snake_ctrl #(
  parameter int STEP_CYCLES = 4000000,
  parameter int MAX_LEN     = 16,
  parameter int H_DISP      = 800,
  parameter int V_DISP      = 600
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic        snack_r,
  output logic        fin,
  output logic [7:0]  score
);
  localparam int TW = $clog2(STEP_CYCLES + 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_dir, r_dir_pend, w_key_dir;
  logic          w_key_any, w_key_ok, w_init;
  logic [6:0]    r_seg_x [MAX_LEN];
  logic [5:0]    r_seg_y [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [TW-1:0] r_timer;
  logic          r_step_pend, r_blank_done;
  logic [15:0]   r_lfsr;
  logic          w_lfsr_fb;
  logic [6:0]    r_food_x, w_fx;
  logic [5:0]    r_food_y, w_fy;
  logic [9:0]    r_box_x, r_box_y;
  logic          r_fin;
  logic [7:0]    r_score;
  logic [7:0]    w_nx_raw;
  logic [6:0]    w_ny_raw;
  logic [6:0]    w_nx;
  logic [5:0]    w_ny;
  logic          w_out, w_hit, w_die, w_eat, w_do_step, w_snack;
  logic [10:0]   w_cell_x, w_cell_y;

  // Direction codes pair up so that a reversal is dir ^ 1.
  always_comb begin
    w_key_dir = D_RIGHT;
    if (key_up)        w_key_dir = D_UP;
    else if (key_down) w_key_dir = D_DOWN;
    else if (key_left) w_key_dir = D_LEFT;
  end
  assign w_key_any = key_up | key_down | key_left | key_right;
  assign w_key_ok  = w_key_any && (w_key_dir != (r_dir ^ 2'd1));

  always_comb begin
    w_nx_raw = {1'b0, r_seg_x[0]};
    w_ny_raw = {1'b0, r_seg_y[0]};
    case (r_dir_pend)
      D_UP:    w_ny_raw = {1'b0, r_seg_y[0]} - 7'd1;
      D_DOWN:  w_ny_raw = {1'b0, r_seg_y[0]} + 7'd1;
      D_LEFT:  w_nx_raw = {1'b0, r_seg_x[0]} - 8'd1;
      default: w_nx_raw = {1'b0, r_seg_x[0]} + 8'd1;
    endcase
`ifdef SNAKE_WALL_WRAP_EN
    w_nx  = (w_nx_raw == 8'hFF) ? 7'd79 : (w_nx_raw == 8'd80) ? 7'd0 : w_nx_raw[6:0];
    w_ny  = (w_ny_raw == 7'h7F) ? 6'd59 : (w_ny_raw == 7'd60) ? 6'd0 : w_ny_raw[5:0];
    w_out = 1'b0;
`else
    w_nx  = w_nx_raw[6:0];
    w_ny  = w_ny_raw[5:0];
    w_out = (w_nx_raw == 8'hFF) || (w_nx_raw == 8'd80) ||
            (w_ny_raw == 7'h7F) || (w_ny_raw == 7'd60);
`endif
  end

  // The tail segment moves away this step, so it is excluded from the hit test.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if ((i < int'(r_len) - 1) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny))
        w_hit = 1'b1;
  end

  assign w_die     = w_out | w_hit;
  assign w_eat     = (w_nx == r_food_x) && (w_ny == r_food_y);
  assign w_do_step = (r_state == S_RUN) && r_step_pend && !r_blank_done &&
                     (pixel_ypos >= 11'(V_DISP));

  assign w_cell_x = pixel_xpos / 11'd10;
  assign w_cell_y = pixel_ypos / 11'd10;
  always_comb begin
    w_snack = 1'b0;
    if ((pixel_xpos < 11'(H_DISP)) && (pixel_ypos < 11'(V_DISP)))
      for (int i = 0; i < MAX_LEN; i++)
        if ((i < int'(r_len)) && ({4'b0, r_seg_x[i]} == w_cell_x) &&
            ({5'b0, r_seg_y[i]} == w_cell_y))
          w_snack = 1'b1;
  end

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_fx = (r_lfsr[6:0] >= 7'd80) ? r_lfsr[6:0] - 7'd80 : r_lfsr[6:0];
  assign w_fy = (r_lfsr[13:8] >= 6'd60) ? r_lfsr[13:8] - 6'd60 : r_lfsr[13:8];

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    case (r_state)
      S_IDLE: if (w_key_any) w_state_nxt = S_RUN;
      S_RUN:  if (w_do_step && w_die) w_state_nxt = S_DEAD;
      S_DEAD: if (w_key_any) begin
        w_state_nxt = S_IDLE;
        w_init      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) r_lfsr <= 16'hACE1;
    else         r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};

    if (sys_rst || w_init) begin
      r_dir      <= D_RIGHT;
      r_dir_pend <= D_RIGHT;
      r_len      <= LW'(3);
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= 7'd0;
        r_seg_y[i] <= 6'd0;
      end
      r_seg_x[0] <= 7'd40;  r_seg_y[0] <= 6'd30;
      r_seg_x[1] <= 7'd39;  r_seg_y[1] <= 6'd30;
      r_seg_x[2] <= 7'd38;  r_seg_y[2] <= 6'd30;
      r_food_x     <= 7'd60;
      r_food_y     <= 6'd30;
      r_box_x      <= 10'd600;
      r_box_y      <= 10'd300;
      r_fin        <= 1'b0;
      r_score      <= 8'd0;
      r_timer      <= '0;
      r_step_pend  <= 1'b0;
      r_blank_done <= 1'b0;
    end else begin
      r_fin <= (w_state_nxt == S_DEAD);
      if ((r_state == S_IDLE) && w_key_ok) begin
        r_dir      <= w_key_dir;
        r_dir_pend <= w_key_dir;
      end
      if (r_state == S_RUN) begin
        if (pixel_ypos < 11'(V_DISP)) r_blank_done <= 1'b0;
        if (w_do_step) begin
          r_step_pend  <= 1'b0;
          r_blank_done <= 1'b1;
          r_dir        <= r_dir_pend;
          if (!w_die) begin
            for (int i = 1; i < MAX_LEN; i++) begin
              r_seg_x[i] <= r_seg_x[i-1];
              r_seg_y[i] <= r_seg_y[i-1];
            end
            r_seg_x[0] <= w_nx;
            r_seg_y[0] <= w_ny;
            if (w_eat) begin
              if (r_len != LW'(MAX_LEN)) r_len <= r_len + LW'(1);
              if (r_score != 8'hFF) r_score <= r_score + 8'd1;
              r_food_x <= w_fx;
              r_food_y <= w_fy;
              r_box_x  <= 10'(w_fx) * 10'd10;
              r_box_y  <= 10'(w_fy) * 10'd10;
            end
          end
        end
        // A timer wrap on the step cycle re-arms the pending step.
        if (r_timer == TW'(STEP_CYCLES - 1)) begin
          r_timer     <= '0;
          r_step_pend <= 1'b1;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
        if (w_key_ok) r_dir_pend <= w_key_dir;
      end
    end
  end

  assign box_x   = r_box_x;
  assign box_y   = r_box_y;
  assign fin     = r_fin;
  assign score   = r_score;
  assign snack_r = w_snack;
endmodule

// File: tb/tb_snake_ctrl.sv
// tb/tb_snake_ctrl.sv - Directed self-checking bench for snake_ctrl (STEP_CYCLES=4).
module tb_snake_ctrl;
  localparam int STEP = 4;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [10:0] pixel_xpos = '0;
  logic [10:0] pixel_ypos = '0;
  logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [9:0]  box_x, box_y;
  logic        snack_r, fin;
  logic [7:0]  score;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [15:0] snap;
  int mx [16];
  int my [16];
  int mlen, mscore, mfx, mfy, mdx, mdy;
  bit mdead;

  always #5 vga_clk = ~vga_clk;

  snake_ctrl #(.STEP_CYCLES(STEP)) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .box_x(box_x), .box_y(box_y), .snack_r(snack_r), .fin(fin), .score(score)
  );

  // Reference LFSR: Fibonacci, taps 16,14,13,11, seeded on reset only.
  always @(posedge vga_clk) begin
    if (sys_rst) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mx[i] = 0; my[i] = 0; end
    mx[0] = 40; my[0] = 30; mx[1] = 39; my[1] = 30; mx[2] = 38; my[2] = 30;
    mlen = 3; mscore = 0; mfx = 60; mfy = 30; mdx = 1; mdy = 0; mdead = 0;
  endtask

  task automatic model_step(input logic [15:0] l);
    int nx, ny;
    bit hit;
    nx = mx[0] + mdx;
    ny = my[0] + mdy;
    hit = 0;
`ifdef SNAKE_WALL_WRAP_EN
    if (nx < 0) nx = 79;
    if (nx > 79) nx = 0;
    if (ny < 0) ny = 59;
    if (ny > 59) ny = 0;
`else
    if (nx < 0 || nx > 79 || ny < 0 || ny > 59) hit = 1;
`endif
    for (int i = 0; i < mlen - 1; i++)
      if (mx[i] == nx && my[i] == ny) hit = 1;
    if (hit) begin
      mdead = 1;
    end else begin
      for (int i = 15; i > 0; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
      mx[0] = nx; my[0] = ny;
      if (nx == mfx && ny == mfy) begin
        if (mlen < 16) mlen++;
        if (mscore < 255) mscore++;
        mfx = int'(l[6:0]);  if (mfx >= 80) mfx -= 80;
        mfy = int'(l[13:8]); if (mfy >= 60) mfy -= 60;
      end
    end
  endtask

  function automatic bit model_snack(input int x, input int y);
    if (x >= 800 || y >= 600) return 0;
    for (int i = 0; i < mlen; i++)
      if (mx[i] == x / 10 && my[i] == y / 10) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input bit exp);
    @(negedge vga_clk);
    pixel_xpos = 11'(x);
    pixel_ypos = 11'(y);
    #1;
    chk(tag, {31'd0, snack_r}, {31'd0, exp});
  endtask

  task automatic pulse(input int k);
    @(posedge vga_clk); #1;
    key_up = (k == 0); key_down = (k == 1); key_left = (k == 2); key_right = (k == 3);
    @(posedge vga_clk); #1;
    key_up = 0; key_down = 0; key_left = 0; key_right = 0;
  endtask

  task automatic run_step();
    @(posedge vga_clk); #1;
    pixel_ypos = 11'd0;
    repeat (STEP + 2) @(posedge vga_clk);
    #1;
    pixel_ypos = 11'd600;
    snap = m_lfsr;
    @(posedge vga_clk); #1;
    pixel_ypos = 11'd0;
    if (!mdead) model_step(snap);
  endtask

  task automatic rst_pulse();
    @(posedge vga_clk); #1;
    sys_rst = 1'b1;
    @(posedge vga_clk); #1;
    sys_rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_box_x"}, 32'(box_x), 32'd600);
    chk({tag, "_box_y"}, 32'(box_y), 32'd300);
    chk({tag, "_fin"},   32'(fin),   32'd0);
    chk({tag, "_score"}, 32'(score), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge vga_clk);
    #1 sys_rst = 1'b0;
    model_reset();

    chk_reset_vals("reset");
    pix("reset_head", 405, 305, 1);
    pix("reset_tail", 385, 305, 1);
    pix("reset_beyond_tail", 375, 305, 0);
    pix("reset_blank_row", 405, 605, 0);

    pulse(3); mdx = 1; mdy = 0;
    run_step();
    pix("step1_head", 415, 305, 1);
    pix("step1_old_tail", 385, 305, 0);
    chk("step1_fin", 32'(fin), 32'd0);

    pulse(2); pulse(0); mdx = 0; mdy = -1;
    run_step();
    pix("turn_up_head", 415, 295, 1);
    pix("turn_neck", 415, 305, model_snack(415, 305));
    pix("turn_tail_vacated", 395, 305, 0);

    @(posedge vga_clk); #1;
    pixel_xpos = 11'd415; pixel_ypos = 11'd100;
    repeat (8) @(posedge vga_clk);
    pix("defer_hold", 415, 285, 0);
    @(negedge vga_clk);
    pixel_ypos = 11'd600;
    snap = m_lfsr;
    repeat (12) @(posedge vga_clk);
    #1;
    model_step(snap);
    pix("defer_step", 415, 285, 1);
    pix("one_step_per_blank", 415, 275, 0);

    repeat (29) run_step();
`ifdef SNAKE_WALL_WRAP_EN
    chk("top_wrap_fin", 32'(fin), 32'd0);
    pix("top_wrap_head", 415, 595, 1);
    pix("top_wrap_model", 415, 5, model_snack(415, 5));
`else
    chk("top_wall_fin", 32'(fin), 32'd1);
    pix("top_wall_frozen", 415, 5, 1);
    pulse(1);
    model_reset();
    chk_reset_vals("key_reinit");
    pix("key_reinit_head", 405, 305, 1);
    pix("key_reinit_old", 415, 5, 0);
`endif

    rst_pulse();
    chk("rst_b_box_x", 32'(box_x), 32'd600);
    pulse(3); mdx = 1; mdy = 0;
    repeat (20) run_step();
    chk("eat_score", 32'(score), 32'd1);
    chk("eat_box_x", 32'(box_x), 32'(mfx * 10));
    chk("eat_box_y", 32'(box_y), 32'(mfy * 10));
    chk("eat_box_x_range", 32'(box_x <= 10'd790), 32'd1);
    chk("eat_box_y_range", 32'(box_y <= 10'd590), 32'd1);
    pix("eat_len4_tail", 575, 305, 1);
    pix("eat_len4_beyond", 565, 305, 0);

    repeat (19) run_step();
    pix("at_right_edge", 795, 305, 1);
    run_step();
`ifdef SNAKE_WALL_WRAP_EN
    chk("right_wrap_fin", 32'(fin), 32'd0);
    pix("right_wrap_head", 5, 305, 1);
`else
    chk("right_wall_fin", 32'(fin), 32'd1);
    pix("right_wall_frozen", 795, 305, 1);
    pix("right_wall_no_wrap", 5, 305, 0);
`endif
    chk("run_score", 32'(score), 32'(mscore));

    rst_pulse();
    chk_reset_vals("rst_dead");
    pix("rst_dead_head", 405, 305, 1);
    pix("rst_dead_tail", 385, 305, 1);
    pix("rst_dead_old", 795, 305, 0);
    pulse(3);
    run_step();
    pix("rst_dead_step_head", 415, 305, 1);
    pix("rst_dead_step_tail", 385, 305, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
